// File: rtl/pipelined_add_sub_if.sv
// Handshake bundle for pipelined_add_sub: operand request side and result side.
// The optional sat signal exists only when ADDSUB_SAT_EN is defined.
interface pipelined_add_sub_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
`ifdef ADDSUB_SAT_EN
  logic             sat;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
  logic             zero;

`ifdef ADDSUB_SAT_EN
  modport master (
    output in_valid, a, b, sub, sat, out_ready,
    input  in_ready, out_valid, result, carry_out, overflow, zero
  );
  modport slave (
    input  in_valid, a, b, sub, sat, out_ready,
    output in_ready, out_valid, result, carry_out, overflow, zero
  );
`else
  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, result, carry_out, overflow, zero
  );
  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, result, carry_out, overflow, zero
  );
`endif
endinterface

// File: rtl/pipelined_add_sub.sv
// Pipelined adder/subtractor: one CHUNK-bit slice per stage with the carry registered between
// stages, valid/ready handshake with a global stall. ADDSUB_SAT_EN adds optional saturation.
module pipelined_add_sub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  pipelined_add_sub_if.slave bus
);
  localparam int STAGES = WIDTH / CHUNK;
  localparam int LAST   = STAGES - 1;

  // Per-stage view of the data entering each stage (stage 0 from the ports).
  logic [WIDTH-1:0] op_a      [STAGES];
  logic [WIDTH-1:0] op_b      [STAGES];
  logic [WIDTH-1:0] part      [STAGES];
  logic             cin       [STAGES];
  logic             v_in      [STAGES];
  logic             s_in      [STAGES];
  logic [CHUNK:0]   slice_sum [STAGES];

  logic             vld_d [STAGES], vld_q [STAGES];
  logic [WIDTH-1:0] opa_d [STAGES], opa_q [STAGES];
  logic [WIDTH-1:0] opb_d [STAGES], opb_q [STAGES];
  logic [WIDTH-1:0] res_d [STAGES], res_q [STAGES];
  logic             cy_d  [STAGES], cy_q  [STAGES];
  logic             sat_d [STAGES], sat_q [STAGES];
  logic             ovf_d, ovf_q;
  logic             zero_d, zero_q;
  logic             advance;

  // The whole pipe moves together; only a held result at the output stalls it.
  assign advance      = !(vld_q[LAST] && !bus.out_ready);
  assign bus.in_ready = advance;

  // NOTE: every variable written here gets a value on every pass, so no latch can be inferred.
  always_comb begin
    op_a[0] = bus.a;
    op_b[0] = bus.b ^ {WIDTH{bus.sub}};
    cin[0]  = bus.sub;
    part[0] = '0;
    v_in[0] = bus.in_valid;
`ifdef ADDSUB_SAT_EN
    s_in[0] = bus.sat;
`else
    s_in[0] = 1'b0;
`endif
    for (int i = 1; i < STAGES; i++) begin
      op_a[i] = opa_q[i-1];
      op_b[i] = opb_q[i-1];
      cin[i]  = cy_q[i-1];
      part[i] = res_q[i-1];
      v_in[i] = vld_q[i-1];
      s_in[i] = sat_q[i-1];
    end

    for (int i = 0; i < STAGES; i++) begin
      slice_sum[i] = {1'b0, op_a[i][i*CHUNK +: CHUNK]}
                   + {1'b0, op_b[i][i*CHUNK +: CHUNK]}
                   + {{CHUNK{1'b0}}, cin[i]};
      res_d[i]                    = part[i];
      res_d[i][i*CHUNK +: CHUNK]  = slice_sum[i][CHUNK-1:0];
      cy_d[i]                     = slice_sum[i][CHUNK];
      opa_d[i]                    = op_a[i];
      opb_d[i]                    = op_b[i];
      vld_d[i]                    = v_in[i];
      sat_d[i]                    = s_in[i];
    end

    // Signed overflow: operands of equal sign producing a result of the other sign.
    ovf_d = (op_a[LAST][WIDTH-1] == op_b[LAST][WIDTH-1]) &&
            (res_d[LAST][WIDTH-1] != op_a[LAST][WIDTH-1]);
    if (sat_d[LAST] && ovf_d) begin
      res_d[LAST] = op_a[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                        : {1'b0, {(WIDTH-1){1'b1}}};
    end
    zero_d = (res_d[LAST] == '0);
  end

  // NOTE: data registers are reset too, so the result and flags read 0 straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        vld_q[i] <= 1'b0;
        opa_q[i] <= '0;
        opb_q[i] <= '0;
        res_q[i] <= '0;
        cy_q[i]  <= 1'b0;
        sat_q[i] <= 1'b0;
      end
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (advance) begin
      // NOTE: non-blocking assignments so every stage samples its predecessor's old value.
      for (int i = 0; i < STAGES; i++) begin
        vld_q[i] <= vld_d[i];
        opa_q[i] <= opa_d[i];
        opb_q[i] <= opb_d[i];
        res_q[i] <= res_d[i];
        cy_q[i]  <= cy_d[i];
        sat_q[i] <= sat_d[i];
      end
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign bus.out_valid = vld_q[LAST];
  assign bus.result    = res_q[LAST];
  assign bus.carry_out = cy_q[LAST];
  assign bus.overflow  = ovf_q;
  assign bus.zero      = zero_q;

endmodule

// File: doc/pipelined_add_sub.md
Name: pipelined_add_sub

Overview:
- Parametrised, pipelined integer adder/subtractor for the MIPS datapath.
- Splits a WIDTH-bit add or subtract into CHUNK-bit slices, one slice per pipeline stage, with the carry registered between stages.
- Uses a valid/ready handshake and accepts one operation per cycle.
- Produces sum, carry-out, signed-overflow and zero flags for the ALU and branch logic.

Parameters:
- WIDTH, 32, operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits added per pipeline stage; STAGES = WIDTH/CHUNK (≥1).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operation offered.
- in_ready  output  1  operation accepted this cycle when in_valid && in_ready.
- a  input  WIDTH  first operand.
- b  input  WIDTH  second operand.
- sub  input  1  0: a+b; 1: a−b.
- out_valid  output  1  result holds a completed operation.
- out_ready  input  1  consumer takes the result when out_valid && out_ready.
- result  output  WIDTH  sum or difference, modulo 2^WIDTH.
- carry_out  output  1  carry from the MSB; for sub, 1 = no borrow.
- overflow  output  1  signed two's-complement overflow.
- zero  output  1  result == 0.

Behaviour:
- Reset (rst_n low, asynchronous): all stage-valid bits clear; out_valid=0, result=0, carry_out=0, overflow=0, zero=0. in_ready=1 while in reset is released.
- Subtraction is implemented as a + ~b + 1: stage 0 carry-in = sub, b inverted when sub=1.
- Stage i (0..STAGES−1):
  - adds bits [i*CHUNK +: CHUNK] using the registered carry from stage i−1;
  - registers its sum slice, carry, and the unprocessed upper operand bits;
  - registers the sign bits of a and effective b for the overflow computation.
- Final stage:
  - overflow = (sa == sb_eff) && (result MSB != sa);
  - zero and the flags are registered with result.
- Latency: an operation accepted on clock edge k is presented with out_valid=1 after edge k+STAGES−1. With CHUNK=WIDTH this is combinational add, registered once (latency 1).
- Throughput: 1 operation per cycle when out_ready=1.
- Stall rule: advance = !(out_valid && !out_ready).
  - When advance=0, every stage holds.
  - in_ready = advance.
  - Bubbles propagate with valid=0; there is no bubble collapsing.
- Outputs are stable while out_valid=1 and out_ready=0.
- Simultaneous accept and consume with a full pipe: both happen and the pipe shifts by one.
- Ordering: results are returned in acceptance order; none dropped, none duplicated.
- Reset mid-operation: all in-flight operations are discarded; no result is emitted for them after rst_n rises.
- in_valid=0: the stage-0 valid bit is loaded with 0; data registers may hold stale values but are never presented with out_valid=1.

Optional Feature:
- Macro: ADDSUB_SAT_EN.
- Defined:
  - adds input port sat (1 bit), sampled with the operands and pipelined alongside them;
  - if sat=1 and overflow=1, result clamps to 2^(WIDTH−1)−1 when the true result is positive (sa=0), or to −2^(WIDTH−1) when negative (sa=1);
  - overflow and carry_out still report the unsaturated condition;
  - zero reflects the clamped result.
- Undefined: no sat port; result always wraps modulo 2^WIDTH.

Test Plan:
- Run all cases with WIDTH=32, CHUNK=8 (latency 4), out_ready=1 unless stated.
- Add wrap: a=0xFFFFFFFF, b=0x00000001, sub=0 → result=0x00000000, carry_out=1, zero=1, overflow=0, out_valid 4 cycles after accept.
- Signed overflow: a=0x7FFFFFFF, b=1, sub=0 → result=0x80000000, overflow=1, carry_out=0. With ADDSUB_SAT_EN and sat=1 → result=0x7FFFFFFF, overflow=1.
- Subtract borrow: a=5, b=7, sub=1 → result=0xFFFFFFFE, carry_out=0, overflow=0. Then a=7, b=5, sub=1 → result=0x00000002, carry_out=1. Back-to-back, so results appear on consecutive cycles.
- Negative overflow: a=0x80000000, b=1, sub=1 → result=0x7FFFFFFF, overflow=1. With ADDSUB_SAT_EN and sat=1 → result=0x80000000.
- Backpressure: stream 6 operations a=i, b=i (i=1..6); hold out_ready=0 for 3 cycles once the first result is valid → in_ready=0 during those cycles. Results 2,4,6,8,10,12 arrive in order, each exactly once, and result stays stable while stalled.
- Reset mid-operation: 3 operations in flight, pulse rst_n low for 1 cycle → out_valid drops to 0 immediately without waiting for a clock edge. No stale result appears in the 8 cycles after release; the next operation accepted completes with latency 4.
